// File: rtl/vector_pair_stream_loader.sv
// Streaming front-end for the parallel M31 dot-product unit: collects (a, b) element
// pairs into two vector buffers, restarts the unit, waits for its result and hands
// the result out over a valid/ready port.
module vector_pair_stream_loader #(
  parameter int unsigned WORD_WIDTH  = 31,
  parameter int unsigned VECTOR_SIZE = 16,
  parameter int unsigned IDX_WIDTH   = $clog2(VECTOR_SIZE + 1)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  // element-pair input stream
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [WORD_WIDTH-1:0]                  in_a,
  input  logic [WORD_WIDTH-1:0]                  in_b,
  input  logic                                   in_last,
  // dot-product unit side
  output logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] dp_vec1,
  output logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] dp_vec2,
  output logic                                   dp_reset,
  input  logic [WORD_WIDTH-1:0]                  dp_result,
  input  logic                                   dp_valid,
  // result output stream
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [WORD_WIDTH-1:0]                  out_data
);

  localparam int unsigned SelWidth = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
  // All-ones word is the modulus 2^31-1, i.e. a non-canonical encoding of zero.
  localparam logic [WORD_WIDTH-1:0] Modulus = {WORD_WIDTH{1'b1}};
  localparam logic [IDX_WIDTH-1:0]  LastIdx = IDX_WIDTH'(VECTOR_SIZE - 1);

  typedef enum logic [1:0] {StLoad, StStart, StWait, StOut} state_e;

  state_e                                 state_q, state_d;
  logic [IDX_WIDTH-1:0]                   index_q, index_d;
  logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] vec1_q, vec1_d;
  logic [VECTOR_SIZE-1:0][WORD_WIDTH-1:0] vec2_q, vec2_d;
  logic [WORD_WIDTH-1:0]                  out_data_q, out_data_d;

  function automatic logic [WORD_WIDTH-1:0] canonical(input logic [WORD_WIDTH-1:0] x);
    return (x == Modulus) ? '0 : x;
  endfunction

  // Next-state logic: buffer fill, restart pulse, result capture and drain.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    vec1_d     = vec1_q;
    vec2_d     = vec2_q;
    out_data_d = out_data_q;
    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          vec1_d[index_q[SelWidth-1:0]] = canonical(in_a);
          vec2_d[index_q[SelWidth-1:0]] = canonical(in_b);
          index_d = index_q + IDX_WIDTH'(1);
          // Leaving on the last slot keeps index within the buffer while loading.
          if (in_last || (index_q == LastIdx)) begin
            state_d = StStart;
          end
        end
      end
      // dp_valid may still be high from the previous run here, so it is not looked at.
      StStart: state_d = StWait;
      StWait: begin
        if (dp_valid) begin
          out_data_d = canonical(dp_result);
          state_d    = StOut;
        end
      end
      StOut: begin
        if (out_ready) begin
          vec1_d  = '0;
          vec2_d  = '0;
          index_d = '0;
          state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StLoad;
      index_q    <= '0;
      vec1_q     <= '0;
      vec2_q     <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      vec1_q     <= vec1_d;
      vec2_q     <= vec2_d;
      out_data_q <= out_data_d;
    end
  end

  // Outputs decode from registered state; the unit is also held in reset with us.
  always_comb begin
    in_ready  = (state_q == StLoad);
    out_valid = (state_q == StOut);
    dp_reset  = reset | (state_q == StStart);
    out_data  = out_data_q;
    dp_vec1   = vec1_q;
    dp_vec2   = vec2_q;
  end

endmodule

// File: tb/tb_vector_pair_stream_loader.sv
// Bench for vector_pair_stream_loader with a behavioural dot-product unit and a
// result scoreboard.
module tb_vector_pair_stream_loader;

  localparam int unsigned W  = 31;
  localparam int unsigned VS = 16;
  localparam logic [63:0]  P64 = 64'h7FFF_FFFF;
  localparam logic [W-1:0] P31 = 31'h7FFF_FFFF;

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [W-1:0]           in_a;
  logic [W-1:0]           in_b;
  logic                   in_last;
  logic [VS-1:0][W-1:0]   dp_vec1;
  logic [VS-1:0][W-1:0]   dp_vec2;
  logic                   dp_reset;
  logic [W-1:0]           dp_result;
  logic                   dp_valid;
  logic                   out_valid;
  logic                   out_ready;
  logic [W-1:0]           out_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [W-1:0] exp_q[$];
  int           t_q[$];
  logic [W-1:0] sa[VS];
  logic [W-1:0] sb[VS];

  vector_pair_stream_loader #(
    .WORD_WIDTH (W),
    .VECTOR_SIZE(VS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .dp_vec1  (dp_vec1),
    .dp_vec2  (dp_vec2),
    .dp_reset (dp_reset),
    .dp_result(dp_result),
    .dp_valid (dp_valid),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural dot-product unit: result valid VS+1 cycles after its reset drops,
  // and stays valid (stale) until the next restart.
  int          dp_cnt = 0;
  logic [63:0] dp_acc;
  always @(posedge clk) begin
    if (dp_reset) dp_cnt <= 0;
    else if (dp_cnt < int'(VS) + 1) dp_cnt <= dp_cnt + 1;
  end
  assign dp_valid = (dp_cnt == int'(VS) + 1);
  always_comb begin
    dp_acc = '0;
    for (int i = 0; i < int'(VS); i++) begin
      dp_acc = (dp_acc + ((64'(dp_vec1[i]) * 64'(dp_vec2[i])) % P64)) % P64;
    end
    dp_result = dp_acc[W-1:0];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] canon(input logic [W-1:0] x);
    return (x == P31) ? '0 : x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vecs_zero(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < int'(VS); i++) begin
      if (dp_vec1[i] !== '0 || dp_vec2[i] !== '0) bad++;
    end
    check_eq(tag, 64'(bad), 64'd0);
  endtask

  // Streams n beats from sa/sb; returns in the START cycle with the result queued.
  task automatic load_pair(input int n, input bit use_last, input bit gaps);
    logic [63:0]  acc;
    logic [W-1:0] e1, e2;
    int           waited, bad, last_t;
    acc    = '0;
    last_t = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_last  = 1'b1;
        step();
      end
      in_valid = 1'b1;
      in_a     = sa[i];
      in_b     = sb[i];
      in_last  = use_last && (i == n - 1);
      waited   = 0;
      while (!in_ready && waited < 50) begin
        step();
        waited++;
      end
      if (!in_ready) begin
        check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
        break;
      end
      if (i == n - 1) last_t = cyc;
      acc = (acc + ((64'(canon(sa[i])) * 64'(canon(sb[i]))) % P64)) % P64;
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_q.push_back(acc[W-1:0]);
    t_q.push_back(last_t);
    bad = 0;
    for (int i = 0; i < int'(VS); i++) begin
      e1 = (i < n) ? canon(sa[i]) : '0;
      e2 = (i < n) ? canon(sb[i]) : '0;
      if (dp_vec1[i] !== e1 || dp_vec2[i] !== e2) bad++;
    end
    check_eq("vec_contents", 64'(bad), 64'd0);
    check_eq("dp_reset_in_start", 64'(dp_reset), 64'd1);
    check_eq("in_ready_in_start", 64'(in_ready), 64'd0);
  endtask

  task automatic wait_out();
    int           guard, busy_bad, t;
    logic [W-1:0] exp;
    guard    = 0;
    busy_bad = 0;
    while (!out_valid && guard < 100) begin
      if (in_ready) busy_bad++;
      step();
      guard++;
    end
    check_eq("in_ready_low_while_busy", 64'(busy_bad), 64'd0);
    check_eq("out_valid_seen", 64'(out_valid), 64'd1);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      t   = t_q.pop_front();
      check_eq("latency", 64'(cyc - t), 64'(VS + 4));
      check_eq("out_data", 64'(out_data), 64'(exp));
    end
    check_eq("in_ready_in_out", 64'(in_ready), 64'd0);
  endtask

  // Holds the result for 'hold' cycles under backpressure, then accepts it.
  task automatic consume(input int hold);
    logic [W-1:0] held;
    int           bad;
    held     = out_data;
    bad      = 0;
    in_valid = 1'b1;
    in_a     = W'(9);
    in_b     = W'(9);
    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      step();
      if (!out_valid || out_data !== held || in_ready) bad++;
    end
    if (hold > 0) check_eq("backpressure_stable", 64'(bad), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("out_valid_dropped", 64'(out_valid), 64'd0);
    check_eq("in_ready_after_drain", 64'(in_ready), 64'd1);
    check_vecs_zero("vecs_cleared");
  endtask

  int seen;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check_eq("dp_reset_in_reset", 64'(dp_reset), 64'd1);
    reset = 1'b0;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_dp_reset", 64'(dp_reset), 64'd0);
    check_vecs_zero("rst_vecs_zero");

    // a = 1..16, b = 1 -> 136
    for (int i = 0; i < int'(VS); i++) begin sa[i] = W'(i + 1); sb[i] = W'(1); end
    load_pair(VS, 1'b1, 1'b0);
    wait_out();
    consume(0);

    // a = b = -1, no in_last: index-driven completion -> 16
    for (int i = 0; i < int'(VS); i++) begin sa[i] = 31'h7FFF_FFFE; sb[i] = 31'h7FFF_FFFE; end
    load_pair(VS, 1'b0, 1'b0);
    wait_out();
    consume(0);

    // non-canonical a folds to zero -> 0
    for (int i = 0; i < int'(VS); i++) begin sa[i] = P31; sb[i] = W'(5); end
    load_pair(VS, 1'b1, 1'b0);
    wait_out();
    consume(0);

    // early termination after three beats -> 56, then backpressure
    sa[0] = W'(2); sb[0] = W'(5);
    sa[1] = W'(3); sb[1] = W'(6);
    sa[2] = W'(4); sb[2] = W'(7);
    load_pair(3, 1'b1, 1'b0);
    wait_out();
    consume(10);

    // second pair a = 2, b = 3 -> 96
    for (int i = 0; i < int'(VS); i++) begin sa[i] = W'(2); sb[i] = W'(3); end
    load_pair(VS, 1'b1, 1'b0);
    wait_out();
    consume(0);

    // gapped input stream -> 136
    for (int i = 0; i < int'(VS); i++) begin sa[i] = W'(i + 1); sb[i] = W'(1); end
    load_pair(VS, 1'b1, 1'b1);
    wait_out();
    consume(0);

    // reset while waiting on the unit: result discarded
    load_pair(VS, 1'b1, 1'b0);
    repeat (5) step();
    reset = 1'b1;
    #1;
    check_eq("dp_reset_mid_reset", 64'(dp_reset), 64'd1);
    step();
    reset = 1'b0;
    #1;
    check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check_vecs_zero("mid_rst_vecs_zero");
    exp_q.delete();
    t_q.delete();
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (out_valid) seen++;
      step();
    end
    check_eq("no_out_after_reset", 64'(seen), 64'd0);

    // normal load afterwards -> 96
    for (int i = 0; i < int'(VS); i++) begin sa[i] = W'(2); sb[i] = W'(3); end
    load_pair(VS, 1'b1, 1'b0);
    wait_out();
    consume(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
